// File: rtl/ppu_oam_dma.sv
// Sprite DMA engine: a CPU write to DMA_ADDR halts the CPU and copies one 256-byte page
// into PPU OAMDATA, one /CS strobe per byte, stepping only on cpu_cycle_in pulses.
module ppu_oam_dma #(
  parameter logic [15:0] DMA_ADDR    = 16'h4014,
  parameter logic [2:0]  OAMDATA_SEL = 3'h4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cpu_cycle_in,
  input  logic [15:0] cpu_a_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpu_d_in,
  output logic        rdy_out,
  output logic        active_out,
  output logic [15:0] mem_a_out,
  output logic        mem_rd_out,
  input  logic [7:0]  mem_d_in,
  output logic [2:0]  ppu_sel_out,
  output logic        ppu_ncs_out,
  output logic        ppu_r_nw_out,
  output logic [7:0]  ppu_d_out
);

  typedef enum logic [2:0] {StIdle, StHalt, StAlign, StRead, StWrite} state_t;

  state_t      q_state;
  logic [7:0]  q_page;
  logic [7:0]  q_idx;
  logic [7:0]  q_data;
  logic        q_odd;
  logic        q_par;
  logic        q_rdy;
  logic        q_active;
  logic [15:0] q_mem_a;
  logic        q_mem_rd;
  logic [2:0]  q_sel;
  logic        q_ncs;
  logic        q_r_nw;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      q_state  <= StIdle;
      q_page   <= '0;
      q_idx    <= '0;
      q_data   <= '0;
      q_odd    <= 1'b0;
      q_par    <= 1'b0;
      q_rdy    <= 1'b1;
      q_active <= 1'b0;
      q_mem_a  <= '0;
      q_mem_rd <= 1'b0;
      q_sel    <= '0;
      q_ncs    <= 1'b1;
      q_r_nw   <= 1'b1;
    end else if (cpu_cycle_in) begin
      q_odd <= ~q_odd;
      case (q_state)
        StIdle: begin
          if (cpu_a_in == DMA_ADDR && !cpu_r_nw_in) begin
            q_page   <= cpu_d_in;
            q_idx    <= '0;
            q_par    <= q_odd;  // parity of the trigger cycle, before this toggle
            q_state  <= StHalt;
            q_rdy    <= 1'b0;
            q_active <= 1'b1;
          end
        end
        StHalt: begin
          if (q_par) begin
            q_state <= StAlign;
          end else begin
            q_state  <= StRead;
            q_mem_rd <= 1'b1;
            q_mem_a  <= {q_page, q_idx};
          end
        end
        StAlign: begin
          q_state  <= StRead;
          q_mem_rd <= 1'b1;
          q_mem_a  <= {q_page, q_idx};
        end
        StRead: begin
          q_data   <= mem_d_in;
          q_mem_rd <= 1'b0;
          q_ncs    <= 1'b0;
          q_sel    <= OAMDATA_SEL;
          q_r_nw   <= 1'b0;
          q_state  <= StWrite;
        end
        StWrite: begin
          // /CS rises here so the next byte gets its own falling edge
          q_ncs  <= 1'b1;
          q_r_nw <= 1'b1;
          q_sel  <= '0;
          q_data <= '0;
          if (q_idx == 8'hFF) begin
            q_state  <= StIdle;
            q_rdy    <= 1'b1;
            q_active <= 1'b0;
            q_mem_a  <= '0;
          end else begin
            q_idx    <= q_idx + 8'd1;
            q_state  <= StRead;
            q_mem_rd <= 1'b1;
            q_mem_a  <= {q_page, q_idx + 8'd1};
          end
        end
        default: q_state <= StIdle;
      endcase
    end
  end

  assign rdy_out      = q_rdy;
  assign active_out   = q_active;
  assign mem_a_out    = q_mem_a;
  assign mem_rd_out   = q_mem_rd;
  assign ppu_sel_out  = q_sel;
  assign ppu_ncs_out  = q_ncs;
  assign ppu_r_nw_out = q_r_nw;
  assign ppu_d_out    = q_data;

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Scoreboard bench for ppu_oam_dma: stimulus queues expected OAM writes, a negedge
// monitor pops one entry per /CS falling edge and checks data, address, select and r/w.
module tb_ppu_oam_dma;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        cpu_cycle_in;
  logic [15:0] cpu_a_in;
  logic        cpu_r_nw_in;
  logic [7:0]  cpu_d_in;
  logic        rdy_out;
  logic        active_out;
  logic [15:0] mem_a_out;
  logic        mem_rd_out;
  logic [7:0]  mem_d_in;
  logic [2:0]  ppu_sel_out;
  logic        ppu_ncs_out;
  logic        ppu_r_nw_out;
  logic [7:0]  ppu_d_out;

  always #10 clk = ~clk;

  ppu_oam_dma dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .cpu_cycle_in(cpu_cycle_in),
    .cpu_a_in    (cpu_a_in),
    .cpu_r_nw_in (cpu_r_nw_in),
    .cpu_d_in    (cpu_d_in),
    .rdy_out     (rdy_out),
    .active_out  (active_out),
    .mem_a_out   (mem_a_out),
    .mem_rd_out  (mem_rd_out),
    .mem_d_in    (mem_d_in),
    .ppu_sel_out (ppu_sel_out),
    .ppu_ncs_out (ppu_ncs_out),
    .ppu_r_nw_out(ppu_r_nw_out),
    .ppu_d_out   (ppu_d_out)
  );

  // CPU memory: each byte is its low address byte XOR A5
  assign mem_d_in = mem_a_out[7:0] ^ 8'hA5;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;

  exp_t        q_exp[$];
  int          checks = 0;
  int          errors = 0;
  int          gap = 2;
  int          par = 0;
  int          wr_cnt = 0;
  int          low_cnt = 0;
  int          low_run = 0;
  int          stab_viol = 0;
  logic        post_rdy, post_act, post_rd, post_ncs;
  logic        last_pulse = 1'b0;
  logic        last_rst = 1'b1;
  logic        prev_ncs = 1'b1;
  logic [15:0] last_rd_a = '0;
  logic [31:0] snap = '0;
  logic        snap_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    last_pulse <= cpu_cycle_in;
    last_rst   <= rst_in;
  end

  // Monitor: stability between pulses, write scoreboard, /CS low duration
  always @(negedge clk) begin
    logic [31:0] now;
    exp_t e;
    now = {rdy_out, active_out, mem_a_out, mem_rd_out, ppu_sel_out, ppu_ncs_out,
           ppu_r_nw_out, ppu_d_out};
    if (snap_valid && !last_pulse && !last_rst && now !== snap) stab_viol++;
    snap = now;
    snap_valid = 1'b1;
    if (mem_rd_out) last_rd_a = mem_a_out;
    if (prev_ncs && !ppu_ncs_out) begin
      wr_cnt++;
      low_run = 1;
      if (q_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got data %0h addr %0h expected no write at %0t",
                 ppu_d_out, last_rd_a, $time);
      end else begin
        e = q_exp.pop_front();
        chk("wr_data", 32'(ppu_d_out), 32'(e.d));
        chk("wr_addr", 32'(last_rd_a), 32'(e.a));
        chk("wr_sel", 32'(ppu_sel_out), 32'h4);
        chk("wr_rnw", 32'(ppu_r_nw_out), 32'h0);
      end
    end else if (!ppu_ncs_out) begin
      low_run++;
    end else if (!prev_ncs && !last_rst) begin
      chk("ncs_low_clks", 32'(low_run), 32'(gap));
    end
    prev_ncs = ppu_ncs_out;
  end

  // One CPU bus cycle: pulse for one clk, then idle so pulses are 'gap' clks apart
  task automatic cyc(input logic [15:0] a, input logic rnw, input logic [7:0] d);
    cpu_a_in     = a;
    cpu_r_nw_in  = rnw;
    cpu_d_in     = d;
    cpu_cycle_in = 1'b1;
    if (!rdy_out) low_cnt++;
    @(posedge clk);
    #1;
    cpu_cycle_in = 1'b0;
    cpu_a_in     = '0;
    cpu_r_nw_in  = 1'b1;
    cpu_d_in     = '0;
    par++;
    post_rdy = rdy_out;
    post_act = active_out;
    post_rd  = mem_rd_out;
    post_ncs = ppu_ncs_out;
    repeat (gap - 1) @(posedge clk);
    #1;
  endtask

  task automatic push_page(input logic [7:0] page);
    exp_t e;
    for (int i = 0; i < 256; i++) begin
      e.a = {page, 8'(i)};
      e.d = 8'(i) ^ 8'hA5;
      q_exp.push_back(e);
    end
  endtask

  task automatic run_dma(input logic [7:0] page, input int odd, input bit poke);
    int n;
    int first_rd;
    int start;
    if ((par % 2) != odd) cyc(16'h0000, 1'b1, 8'h00);
    push_page(page);
    start   = wr_cnt;
    low_cnt = 0;
    cyc(16'h4014, 1'b0, page);
    chk("rdy_fall_1clk", 32'(post_rdy), 32'h0);
    chk("active_rise_1clk", 32'(post_act), 32'h1);
    n = 0;
    first_rd = 0;
    while (!post_rdy && n < 600) begin
      n++;
      // a second $4014 write mid-transfer must be ignored
      if (poke && n == 10) cyc(16'h4014, 1'b0, 8'h07);
      else cyc(16'h0000, 1'b1, 8'h00);
      if (post_rd && first_rd == 0) first_rd = n;
    end
    chk("first_rd_cycles", 32'(first_rd), (odd != 0) ? 32'd2 : 32'd1);
    chk("rdy_low_pulses", 32'(low_cnt), (odd != 0) ? 32'd514 : 32'd513);
    chk("writes_done", 32'(wr_cnt - start), 32'd256);
    chk("active_recover", 32'(post_act), 32'h0);
    chk("ncs_idle_after", 32'(post_ncs), 32'h1);
    chk("queue_drained", 32'(q_exp.size()), 32'h0);
  endtask

  initial begin
    int n;
    int start;
    rst_in = 1'b1;
    cpu_cycle_in = 1'b0;
    cpu_a_in = '0;
    cpu_r_nw_in = 1'b1;
    cpu_d_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(rdy_out), 32'h1);
    chk("rst_active", 32'(active_out), 32'h0);
    chk("rst_mem_rd", 32'(mem_rd_out), 32'h0);
    chk("rst_mem_a", 32'(mem_a_out), 32'h0);
    chk("rst_ncs", 32'(ppu_ncs_out), 32'h1);
    chk("rst_rnw", 32'(ppu_r_nw_out), 32'h1);
    chk("rst_sel", 32'(ppu_sel_out), 32'h0);
    chk("rst_d", 32'(ppu_d_out), 32'h0);
    rst_in = 1'b0;
    par = 0;

    run_dma(8'h02, 0, 1'b0);
    run_dma(8'h02, 1, 1'b0);
    run_dma(8'hFF, 0, 1'b0);

    cyc(16'h4014, 1'b1, 8'h02);
    chk("read_4014_rdy", 32'(post_rdy), 32'h1);
    chk("read_4014_ncs", 32'(post_ncs), 32'h1);
    cyc(16'h4013, 1'b0, 8'h02);
    chk("write_4013_rdy", 32'(post_rdy), 32'h1);
    cyc(16'h4015, 1'b0, 8'h02);
    chk("write_4015_rdy", 32'(post_rdy), 32'h1);
    cyc(16'h0000, 1'b1, 8'h00);
    chk("ignored_still_idle", 32'(post_rdy), 32'h1);

    // Reset during the 100th WRITE
    if ((par % 2) != 0) cyc(16'h0000, 1'b1, 8'h00);
    push_page(8'h05);
    start = wr_cnt;
    cyc(16'h4014, 1'b0, 8'h05);
    n = 0;
    while ((wr_cnt - start) < 100 && n < 600) begin
      n++;
      cyc(16'h0000, 1'b1, 8'h00);
    end
    chk("reached_write_100", 32'(wr_cnt - start), 32'd100);
    rst_in = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ncs", 32'(ppu_ncs_out), 32'h1);
    chk("abort_rdy", 32'(rdy_out), 32'h1);
    chk("abort_active", 32'(active_out), 32'h0);
    chk("abort_mem_rd", 32'(mem_rd_out), 32'h0);
    rst_in = 1'b0;
    par = 0;
    q_exp.delete();
    repeat (20) cyc(16'h0000, 1'b1, 8'h00);
    chk("abort_no_more_writes", 32'(wr_cnt - start), 32'd100);
    chk("abort_rdy_held", 32'(post_rdy), 32'h1);

    // Sparse pulses
    gap = 24;
    run_dma(8'h03, 0, 1'b1);

    chk("stable_between_pulses", 32'(stab_viol), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_oam_dma.md
Name: ppu_oam_dma

Overview:
- CPU-side initiator for the PPU register interface; performs NES sprite DMA (write to $4014).
- On a $4014 write it halts the CPU via rdy_out, reads 256 bytes from CPU page {page,00}..{page,FF}, and writes each byte to PPU register 0x2004.
- Drives sel/ncs/r_nw/data exactly as a CPU access, one falling /CS edge per byte; the PPU auto-increments its sprite RAM pointer.
- Sits between the CPU bus arbiter and the PPU, alongside the CPU core.

Parameters:
- DMA_ADDR, 16'h4014, CPU address that triggers DMA.
- OAMDATA_SEL, 3'h4, PPU register select used for each byte write.

Ports:
- clk_in  input  1  50MHz system clock.
- rst_in  input  1  reset; synchronous, active-high.
- cpu_cycle_in  input  1  one-clk pulse marking the end of each CPU bus cycle. All DMA state advances only on this pulse.
- cpu_a_in  input  16  CPU address bus (valid at cpu_cycle_in).
- cpu_r_nw_in  input  1  CPU read/write (1=read).
- cpu_d_in  input  8  CPU write data.
- rdy_out  output  1  0 halts CPU.
- active_out  output  1  1 while DMA owns the bus.
- mem_a_out  output  16  DMA read address to CPU memory.
- mem_rd_out  output  1  DMA read strobe for the current CPU cycle.
- mem_d_in  input  8  CPU memory read data (valid at cpu_cycle_in).
- ppu_sel_out  output  3  PPU register select.
- ppu_ncs_out  output  1  PPU chip select, active low.
- ppu_r_nw_out  output  1  PPU read/write.
- ppu_d_out  output  8  PPU write data.

Behaviour:
- Registered state: q_state, q_page[7:0], q_idx[7:0], q_data[7:0], q_odd. All outputs decode from registered state only.
- q_odd toggles on every cpu_cycle_in, including during DMA. It resets to 0.
- Reset values:
  - state IDLE; rdy_out=1; active_out=0; mem_rd_out=0; mem_a_out=0.
  - ppu_ncs_out=1, ppu_r_nw_out=1, ppu_sel_out=0, ppu_d_out=0.
  - q_page=q_idx=q_data=0.
- IDLE:
  - On cpu_cycle_in with cpu_a_in==DMA_ADDR and cpu_r_nw_in==0: latch q_page=cpu_d_in, set q_idx=0, record the parity of the write cycle (q_odd before toggle), go HALT.
  - Reads of DMA_ADDR are ignored.
- HALT: rdy_out=0, active_out=1, no bus activity. At next cpu_cycle_in go ALIGN if the recorded parity is odd, else go READ.
- ALIGN: one idle CPU cycle, then READ.
- READ: mem_a_out={q_page,q_idx}, mem_rd_out=1, ppu_ncs_out=1. At cpu_cycle_in latch q_data=mem_d_in and go WRITE.
- WRITE:
  - Drive ppu_ncs_out=0, ppu_sel_out=OAMDATA_SEL, ppu_r_nw_out=0, ppu_d_out=q_data, mem_rd_out=0.
  - At cpu_cycle_in: if q_idx==8'hFF go IDLE; else q_idx=q_idx+1 and go READ.
- Outputs change on the clock after a cpu_cycle_in pulse and hold stable until the next pulse.
- /CS is high for the whole READ cycle, so every byte produces exactly one falling edge.
- Latency: rdy_out falls one clk after the $4014 write pulse.
- CPU cycles with rdy_out=0:
  - 513 for an even-parity trigger (1 HALT + 256×2).
  - 514 for an odd-parity trigger (adds ALIGN).
- rdy_out returns to 1 one clk after the final WRITE pulse.
- q_idx is 8 bits and wrap is not possible; termination is by the FF compare.
- Page FF is legal: addresses FF00..FFFF.
- $4014 writes while not in IDLE are ignored; the CPU is halted anyway.
- Reset mid-transfer:
  - Abort on the next clk: all outputs return to reset values and rdy_out=1.
  - No further PPU writes; a partial sprite RAM fill remains.
- Behaviour is independent of the spacing between cpu_cycle_in pulses (≥2 clks).

Test Plan:
- Even-parity write of 8'h02 to $4014, memory byte = low address byte XOR 8'hA5:
  - exactly 256 ppu_ncs_out falling edges, all with sel=4 and r_nw=0;
  - data sequence A5,A4,…;
  - mem_a_out runs 0200..02FF;
  - rdy_out low for 513 cpu_cycle_in pulses.
- Same trigger issued on an odd-parity cycle:
  - rdy_out low for 514 pulses;
  - first mem_rd_out asserted 2 CPU cycles after the trigger.
- Trigger with page 8'hFF:
  - final mem_a_out is FFFF;
  - active_out and rdy_out recover one clk after the 256th write pulse.
- Assert rst_in during the 100th WRITE:
  - next clk: ppu_ncs_out=1, rdy_out=1, active_out=0;
  - write count stays at 99 or 100 and never grows afterward.
- Read of $4014, and writes to $4013 and $4015:
  - rdy_out stays 1 and ppu_ncs_out stays 1.
- cpu_cycle_in every 24 clks, trigger page 8'h03:
  - outputs stay constant between pulses;
  - each WRITE holds ncs low for 24 clks;
  - results are identical to the dense-pulse run.
